// File: rtl/hrm_ctrl_mc.sv
// Microcoded control FSM for the HRM instruction set: sequences fetch/decode/execute
// strobes for the datapath and counts retired instructions.
module hrm_ctrl_mc #(
    parameter int unsigned IW    = 8,
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic [IW-1:0]        INSTR,
    input  logic [(2**CH_W)-1:0] inEmpty,
    input  logic [(2**CH_W)-1:0] outFull,
    input  logic                 mem_rdy,
    input  logic                 debug,
    input  logic                 nxtInstr,
    output logic                 wIR,
    output logic                 wR,
    output logic                 srcA,
    output logic                 wM,
    output logic                 wAR,
    output logic                 wPC,
    output logic                 rIn,
    output logic                 wO,
    output logic                 ijump,
    output logic                 branch,
    output logic                 rst,
    output logic                 halt,
    output logic [1:0]           muxR,
    output logic [2:0]           aluCtl,
    output logic [CH_W-1:0]      ch_sel,
    output logic                 retire,
    output logic [CNT_W-1:0]     icount
);

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPP    = 4'h6;
    localparam logic [3:0] OP_BUMPN    = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_HALT     = 4'hF;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH_I, S_WAIT_KEY, S_LOAD_IR, S_DECODE, S_INBOX, S_OUTBOX,
        S_INCPC, S_INCPC2, S_FETCH_O, S_LOAD_AR, S_READMEM, S_READMEM2, S_LOAD_AR2,
        S_COPYFROM, S_COPYTO, S_ADD, S_SUB, S_BUMPP, S_BUMPN, S_JUMP, S_JUMPZ,
        S_JUMPN, S_HALT
    } state_t;

    typedef struct packed {
        logic       wir;
        logic       wr;
        logic       srca;
        logic       wm;
        logic       war;
        logic       wpc;
        logic       rin;
        logic       wo;
        logic       ijump;
        logic       branch;
        logic       rst;
        logic       halt;
        logic [1:0] mux_r;
        logic [2:0] alu_ctl;
        logic       retire;
    } strobes_t;

    localparam strobes_t OUT_RESET = '{rst: 1'b1, default: '0};

    state_t     state;
    state_t     state_next;
    strobes_t   out_d;
    strobes_t   out_q;
    logic [3:0] opcode;
    logic       indirect;
    logic       in_empty_ch;
    logic       out_full_ch;
    logic       instr_unused;

    assign opcode       = INSTR[IW-1 -: 4];
    assign indirect     = INSTR[IW-5];
    assign ch_sel       = INSTR[CH_W-1:0];
    assign in_empty_ch  = inEmpty[ch_sel];
    assign out_full_ch  = outFull[ch_sel];
    assign instr_unused = ^INSTR;

    // State and Moore strobes are registered together so outputs track the state exactly.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_RESET;
            out_q <= OUT_RESET;
        end else begin
            state <= state_next;
            out_q <= out_d;
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            icount <= '0;
        end else if (out_q.retire && (icount != {CNT_W{1'b1}})) begin
            icount <= icount + CNT_W'(1);
        end
    end

    // Next-state logic, then the strobe decode of the state being entered.
    always_comb begin
        state_next = state;
        out_d      = '0;

        case (state)
            S_RESET:    state_next = S_FETCH_I;
            S_FETCH_I:  if (mem_rdy) state_next = debug ? S_WAIT_KEY : S_LOAD_IR;
            S_WAIT_KEY: if (nxtInstr) state_next = S_LOAD_IR;
            S_LOAD_IR:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_INBOX:  if (!in_empty_ch) state_next = S_INBOX;
                    OP_OUTBOX: if (!out_full_ch) state_next = S_OUTBOX;
                    OP_HALT:   state_next = S_HALT;
                    4'hB, 4'hC, 4'hD, 4'hE: state_next = S_INCPC;
                    default:   state_next = S_INCPC2;
                endcase
            end
            S_INCPC2:   state_next = S_FETCH_O;
            S_FETCH_O: begin
                if (mem_rdy) begin
                    case (opcode)
                        OP_JUMP:  state_next = S_JUMP;
                        OP_JUMPZ: state_next = S_JUMPZ;
                        OP_JUMPN: state_next = S_JUMPN;
                        default:  state_next = S_LOAD_AR;
                    endcase
                end
            end
            S_LOAD_AR: begin
                if (indirect)                  state_next = S_READMEM2;
                else if (opcode == OP_COPYTO)  state_next = S_COPYTO;
                else                           state_next = S_READMEM;
            end
            S_READMEM2: if (mem_rdy) state_next = S_LOAD_AR2;
            S_LOAD_AR2: state_next = (opcode == OP_COPYTO) ? S_COPYTO : S_READMEM;
            S_READMEM: begin
                if (mem_rdy) begin
                    case (opcode)
                        OP_BUMPP:    state_next = S_BUMPP;
                        OP_BUMPN:    state_next = S_BUMPN;
                        OP_COPYFROM: state_next = S_COPYFROM;
                        OP_ADD:      state_next = S_ADD;
                        OP_SUB:      state_next = S_SUB;
                        default:     state_next = S_HALT;
                    endcase
                end
            end
            S_BUMPP, S_BUMPN: state_next = S_COPYTO;
            S_INBOX, S_OUTBOX, S_COPYFROM, S_COPYTO, S_ADD, S_SUB: state_next = S_INCPC;
            S_INCPC, S_JUMP, S_JUMPZ, S_JUMPN: state_next = S_FETCH_I;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_HALT;
        endcase

        case (state_next)
            S_RESET:    out_d.rst = 1'b1;
            S_LOAD_IR:  out_d.wir = 1'b1;
            S_INCPC: begin
                out_d.wpc    = 1'b1;
                out_d.retire = 1'b1;
            end
            S_INCPC2:   out_d.wpc = 1'b1;
            S_LOAD_AR:  out_d.war = 1'b1;
            S_LOAD_AR2: begin
                out_d.war  = 1'b1;
                out_d.srca = 1'b1;
            end
            S_COPYTO:   out_d.wm   = 1'b1;
            S_OUTBOX:   out_d.wo   = 1'b1;
            S_HALT:     out_d.halt = 1'b1;
            S_INBOX: begin
                out_d.rin   = 1'b1;
                out_d.wr    = 1'b1;
                out_d.mux_r = 2'b00;
            end
            S_COPYFROM: begin
                out_d.wr    = 1'b1;
                out_d.mux_r = 2'b01;
            end
            S_ADD, S_SUB, S_BUMPP, S_BUMPN: begin
                out_d.wr    = 1'b1;
                out_d.mux_r = 2'b11;
                case (state_next)
                    S_SUB:   out_d.alu_ctl = 3'b001;
                    S_BUMPP: out_d.alu_ctl = 3'b010;
                    S_BUMPN: out_d.alu_ctl = 3'b011;
                    default: out_d.alu_ctl = 3'b000;
                endcase
            end
            S_JUMP: begin
                out_d.branch = 1'b1;
                out_d.ijump  = 1'b1;
                out_d.wpc    = 1'b1;
                out_d.retire = 1'b1;
            end
            S_JUMPZ: begin
                out_d.branch  = 1'b1;
                out_d.wpc     = 1'b1;
                out_d.retire  = 1'b1;
                out_d.alu_ctl = 3'b000;
            end
            S_JUMPN: begin
                out_d.branch  = 1'b1;
                out_d.wpc     = 1'b1;
                out_d.retire  = 1'b1;
                out_d.alu_ctl = 3'b100;
            end
            default: ;
        endcase
    end

    assign wIR    = out_q.wir;
    assign wR     = out_q.wr;
    assign srcA   = out_q.srca;
    assign wM     = out_q.wm;
    assign wAR    = out_q.war;
    assign wPC    = out_q.wpc;
    assign rIn    = out_q.rin;
    assign wO     = out_q.wo;
    assign ijump  = out_q.ijump;
    assign branch = out_q.branch;
    assign rst    = out_q.rst;
    assign halt   = out_q.halt;
    assign muxR   = out_q.mux_r;
    assign aluCtl = out_q.alu_ctl;
    assign retire = out_q.retire;

endmodule

// File: tb/tb_hrm_ctrl_mc.sv
// Scoreboard bench for hrm_ctrl_mc: expected strobe vectors are queued as stimulus is
// driven and compared one per clock; a CNT_W=4 twin checks counter saturation.
module tb_hrm_ctrl_mc;

    localparam int unsigned CH_W = 2;
    localparam int unsigned NCH  = 4;

    // Expected vector: {wIR,wR,srcA,wM,wAR,wPC,rIn,wO,ijump,branch,rst,halt,muxR,aluCtl,retire}
    localparam logic [17:0] V_RESET    = 18'h00080;
    localparam logic [17:0] V_FETCH_I  = 18'h00000;
    localparam logic [17:0] V_WAIT_KEY = 18'h00000;
    localparam logic [17:0] V_LOAD_IR  = 18'h20000;
    localparam logic [17:0] V_DECODE   = 18'h00000;
    localparam logic [17:0] V_INCPC    = 18'h01001;
    localparam logic [17:0] V_INCPC2   = 18'h01000;
    localparam logic [17:0] V_FETCH_O  = 18'h00000;
    localparam logic [17:0] V_LOAD_AR  = 18'h02000;
    localparam logic [17:0] V_READMEM  = 18'h00000;
    localparam logic [17:0] V_READMEM2 = 18'h00000;
    localparam logic [17:0] V_LOAD_AR2 = 18'h0A000;
    localparam logic [17:0] V_COPYTO   = 18'h04000;
    localparam logic [17:0] V_OUTBOX   = 18'h00400;
    localparam logic [17:0] V_HALT     = 18'h00040;
    localparam logic [17:0] V_INBOX    = 18'h10800;
    localparam logic [17:0] V_COPYFROM = 18'h10010;
    localparam logic [17:0] V_ADD      = 18'h10030;
    localparam logic [17:0] V_SUB      = 18'h10032;
    localparam logic [17:0] V_BUMPP    = 18'h10034;
    localparam logic [17:0] V_BUMPN    = 18'h10036;
    localparam logic [17:0] V_JUMP     = 18'h01301;
    localparam logic [17:0] V_JUMPZ    = 18'h01101;
    localparam logic [17:0] V_JUMPN    = 18'h01109;

    logic            clk;
    logic            i_rst_n;
    logic [7:0]      INSTR;
    logic [NCH-1:0]  inEmpty;
    logic [NCH-1:0]  outFull;
    logic            mem_rdy;
    logic            debug;
    logic            nxtInstr;

    logic wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt, retire;
    logic [1:0]      muxR;
    logic [2:0]      aluCtl;
    logic [CH_W-1:0] ch_sel;
    logic [15:0]     icount;

    logic wIR4, wR4, srcA4, wM4, wAR4, wPC4, rIn4, wO4, ijump4, branch4, rst4, halt4, retire4;
    logic [1:0]      muxR4;
    logic [2:0]      aluCtl4;
    logic [CH_W-1:0] ch_sel4;
    logic [3:0]      icount4;

    logic [17:0]     obs;
    logic [17:0]     sb_q[$];
    logic [17:0]     mon_exp;
    string           cur_tag;
    int              n_tests;
    int              n_fail;
    int              exp_cnt;

    hrm_ctrl_mc dut (
        .clk(clk), .i_rst_n(i_rst_n), .INSTR(INSTR), .inEmpty(inEmpty), .outFull(outFull),
        .mem_rdy(mem_rdy), .debug(debug), .nxtInstr(nxtInstr),
        .wIR(wIR), .wR(wR), .srcA(srcA), .wM(wM), .wAR(wAR), .wPC(wPC), .rIn(rIn), .wO(wO),
        .ijump(ijump), .branch(branch), .rst(rst), .halt(halt), .muxR(muxR), .aluCtl(aluCtl),
        .ch_sel(ch_sel), .retire(retire), .icount(icount)
    );

    hrm_ctrl_mc #(.CNT_W(4)) dut4 (
        .clk(clk), .i_rst_n(i_rst_n), .INSTR(INSTR), .inEmpty(inEmpty), .outFull(outFull),
        .mem_rdy(mem_rdy), .debug(debug), .nxtInstr(nxtInstr),
        .wIR(wIR4), .wR(wR4), .srcA(srcA4), .wM(wM4), .wAR(wAR4), .wPC(wPC4), .rIn(rIn4),
        .wO(wO4), .ijump(ijump4), .branch(branch4), .rst(rst4), .halt(halt4), .muxR(muxR4),
        .aluCtl(aluCtl4), .ch_sel(ch_sel4), .retire(retire4), .icount(icount4)
    );

    assign obs = {wIR, wR, srcA, wM, wAR, wPC, rIn, wO, ijump, branch, rst, halt,
                  muxR, aluCtl, retire};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard drain: one expected vector per rising edge, sampled 2 time units later.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            chk(cur_tag, 32'(obs), 32'(mon_exp));
        end
    end

    // Called at a falling edge with inputs already set: queue the state entered next edge.
    task automatic cyc(input logic [17:0] e);
        sb_q.push_back(e);
        if (e[0]) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, 32'(icount), 32'((exp_cnt > 65535) ? 65535 : exp_cnt));
        chk({tag, "_w4"}, 32'(icount4), 32'((exp_cnt > 15) ? 15 : exp_cnt));
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        chk("rst_outs", 32'(obs), 32'(V_RESET));
        chk("rst_cnt", 32'(icount), 32'd0);
        chk("rst_cnt_w4", 32'(icount4), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        chk("rst_release", 32'(obs), 32'(V_RESET));
        cur_tag = "rst_first_edge";
        cyc(V_FETCH_I);
    endtask

    task automatic fetch_decode(input logic [7:0] ins);
        INSTR = ins;
        cyc(V_LOAD_IR);
        cyc(V_DECODE);
    endtask

    task automatic mem_op(input string tag, input logic [7:0] ins, input logic [17:0] v_exec,
                          input int stalls, input bit bump);
        cur_tag = tag;
        fetch_decode(ins);
        cyc(V_INCPC2);
        cyc(V_FETCH_O);
        cyc(V_LOAD_AR);
        cyc(V_READMEM);
        mem_rdy = 1'b0;
        repeat (stalls) cyc(V_READMEM);
        mem_rdy = 1'b1;
        cyc(v_exec);
        if (bump) cyc(V_COPYTO);
        cyc(V_INCPC);
        cyc(V_FETCH_I);
        chk_cnt({tag, "_cnt"});
    endtask

    task automatic jump_op(input string tag, input logic [7:0] ins, input logic [17:0] v_exec,
                           input int stalls);
        cur_tag = tag;
        fetch_decode(ins);
        cyc(V_INCPC2);
        mem_rdy = 1'b0;
        cyc(V_FETCH_O);
        repeat (stalls) cyc(V_FETCH_O);
        mem_rdy = 1'b1;
        cyc(v_exec);
        cyc(V_FETCH_I);
        chk_cnt({tag, "_cnt"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        cur_tag  = "init";
        i_rst_n  = 1'b1;
        INSTR    = 8'h10;
        inEmpty  = '0;
        outFull  = '0;
        mem_rdy  = 1'b1;
        debug    = 1'b0;
        nxtInstr = 1'b0;
        @(negedge clk);
        do_reset();

        // OUTBOX ch0 straight through
        cur_tag = "outbox";
        fetch_decode(8'h10);
        cyc(V_OUTBOX);
        cyc(V_INCPC);
        cyc(V_FETCH_I);
        chk_cnt("outbox_cnt");

        // INBOX ch2 waits on its own empty flag only
        cur_tag = "inbox_wait";
        inEmpty = 4'b0100;
        fetch_decode(8'h02);
        repeat (4) cyc(V_DECODE);
        inEmpty = 4'b1011;
        cyc(V_INBOX);
        chk("inbox_ch_sel", 32'(ch_sel), 32'd2);
        inEmpty = '0;
        cyc(V_INCPC);
        cyc(V_FETCH_I);
        chk_cnt("inbox_cnt");

        // OUTBOX ch3 waits on its own full flag only
        cur_tag = "outbox_wait";
        outFull = 4'b1000;
        fetch_decode(8'h13);
        repeat (2) cyc(V_DECODE);
        outFull = 4'b0111;
        cyc(V_OUTBOX);
        chk("outbox_ch_sel", 32'(ch_sel), 32'd3);
        outFull = '0;
        cyc(V_INCPC);
        cyc(V_FETCH_I);
        chk_cnt("outbox_wait_cnt");

        // ADD indirect with memory stall in READMEM2
        cur_tag = "add_ind";
        fetch_decode(8'h4B);
        cyc(V_INCPC2);
        cyc(V_FETCH_O);
        cyc(V_LOAD_AR);
        cyc(V_READMEM2);
        mem_rdy = 1'b0;
        repeat (3) cyc(V_READMEM2);
        mem_rdy = 1'b1;
        cyc(V_LOAD_AR2);
        cyc(V_READMEM);
        cyc(V_ADD);
        cyc(V_INCPC);
        cyc(V_FETCH_I);
        chk_cnt("add_ind_cnt");

        mem_op("sub", 8'h50, V_SUB, 2, 1'b0);
        mem_op("bump_p", 8'h61, V_BUMPP, 0, 1'b1);
        mem_op("bump_n", 8'h72, V_BUMPN, 1, 1'b1);
        mem_op("copyfrom", 8'h23, V_COPYFROM, 1, 1'b0);

        jump_op("jump", 8'h80, V_JUMP, 0);
        jump_op("jumpz", 8'h95, V_JUMPZ, 2);
        jump_op("jumpn", 8'hA0, V_JUMPN, 1);

        // Fetch stall, then single-step wait
        cur_tag = "debug_step";
        mem_rdy = 1'b0;
        repeat (2) cyc(V_FETCH_I);
        mem_rdy = 1'b1;
        debug = 1'b1;
        cyc(V_WAIT_KEY);
        repeat (6) cyc(V_WAIT_KEY);
        nxtInstr = 1'b1;
        cyc(V_LOAD_IR);
        nxtInstr = 1'b0;
        debug = 1'b0;
        INSTR = 8'hB0;
        cyc(V_DECODE);
        cyc(V_INCPC);
        cyc(V_FETCH_I);
        chk_cnt("debug_cnt");

        // COPYTO indirect
        cur_tag = "copyto_ind";
        fetch_decode(8'h38);
        cyc(V_INCPC2);
        cyc(V_FETCH_O);
        cyc(V_LOAD_AR);
        cyc(V_READMEM2);
        cyc(V_LOAD_AR2);
        cyc(V_COPYTO);
        cyc(V_INCPC);
        cyc(V_FETCH_I);
        chk_cnt("copyto_ind_cnt");

        // Reset asserted mid-COPYTO
        cur_tag = "copyto_rst";
        fetch_decode(8'h31);
        cyc(V_INCPC2);
        cyc(V_FETCH_O);
        cyc(V_LOAD_AR);
        cyc(V_COPYTO);
        do_reset();

        // NOP run: the 4-bit counter saturates at 15
        cur_tag = "nops";
        for (int i = 0; i < 20; i++) begin
            INSTR = 8'(8'hB0 + ((i % 4) << 4));
            cyc(V_LOAD_IR);
            cyc(V_DECODE);
            cyc(V_INCPC);
            cyc(V_FETCH_I);
            if (i == 14) chk_cnt("nop15_cnt");
        end
        chk_cnt("nop20_cnt");

        // Opcode altered under READMEM: unhandled op falls into HALT
        cur_tag = "readmem_halt";
        fetch_decode(8'h40);
        cyc(V_INCPC2);
        cyc(V_FETCH_O);
        cyc(V_LOAD_AR);
        cyc(V_READMEM);
        INSTR = 8'h00;
        cyc(V_HALT);
        cyc(V_HALT);
        chk_cnt("readmem_halt_cnt");
        do_reset();

        // HALT opcode holds until reset
        cur_tag = "halt";
        fetch_decode(8'hF0);
        cyc(V_HALT);
        mem_rdy = 1'b0;
        nxtInstr = 1'b1;
        repeat (3) cyc(V_HALT);
        mem_rdy = 1'b1;
        nxtInstr = 1'b0;
        chk_cnt("halt_cnt");

        @(posedge clk);
        #3;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
